// File: rtl/fp_pkg.sv
// Shared types, flag bit positions and format helpers for the FP adder datapath.
package fp_pkg;

  typedef logic [5:0] fp_flags_t;

  localparam int unsigned FLG_SNAN = 5;
  localparam int unsigned FLG_QNAN = 4;
  localparam int unsigned FLG_INF  = 3;
  localparam int unsigned FLG_ZERO = 2;
  localparam int unsigned FLG_SUB  = 1;
  localparam int unsigned FLG_NORM = 0;

  function automatic int unsigned exp_len(input int unsigned precision);
    case (precision)
      16:      return 5;
      32:      return 8;
      64:      return 11;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned man_len(input int unsigned precision);
    case (precision)
      16:      return 10;
      32:      return 23;
      64:      return 52;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous valid/ready FIFO with extra-bit pointers; output is always taken from storage.
module fp_sync_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic             push, pop;

  // Pointer difference is exact because both pointers carry one wrap bit.
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign in_ready  = (occupancy != PW'(DEPTH));
  assign out_valid = (occupancy != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_result_stage.sv
// Registered result stage for the FP adder: result FIFO plus sticky class/exception status.
// Optional per-class event counters are enabled with the FP_STAT_CNT_EN macro.
module fp_result_stage
  import fp_pkg::*;
#(
  parameter int unsigned PRECISION  = 16,
  parameter int unsigned FIFO_DEPTH = 4
`ifdef FP_STAT_CNT_EN
  ,
  parameter int unsigned CNT_W      = 16
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PRECISION-1:0]        in_sum,
  input  fp_flags_t                   in_flags,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PRECISION-1:0]        out_sum,
  output fp_flags_t                   out_flags,
  output logic [$clog2(FIFO_DEPTH):0] occupancy,
`ifdef FP_STAT_CNT_EN
  input  logic [2:0]                  cnt_sel,
  output logic [CNT_W-1:0]            cnt_val,
`endif
  input  logic                        sticky_clr,
  output fp_flags_t                   sticky,
  output logic                        flag_err
);

  localparam int unsigned Width = PRECISION + 6;

  logic             push;
  logic             bad_flags;
  fp_flags_t        sticky_q, sticky_d;
  logic             flag_err_q, flag_err_d;
  logic [Width-1:0] head_data;

  fp_sync_fifo #(
    .WIDTH (Width),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_sum, in_flags}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_data),
    .occupancy (occupancy)
  );

  assign out_sum   = head_data[Width-1:6];
  assign out_flags = head_data[5:0];
  assign push      = in_valid & in_ready;
  assign bad_flags = ($countones(in_flags) != 1);

  // Clear first, then merge the accepted event so a same-cycle event survives the clear.
  always_comb begin
    sticky_d   = sticky_q;
    flag_err_d = flag_err_q;
    if (sticky_clr) begin
      sticky_d   = '0;
      flag_err_d = 1'b0;
    end
    if (push) begin
      sticky_d   = sticky_d | in_flags;
      flag_err_d = flag_err_d | bad_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q   <= '0;
      flag_err_q <= 1'b0;
    end else begin
      sticky_q   <= sticky_d;
      flag_err_q <= flag_err_d;
    end
  end

  assign sticky   = sticky_q;
  assign flag_err = flag_err_q;

`ifdef FP_STAT_CNT_EN
  localparam int unsigned NumCnt = 7;

  logic [CNT_W-1:0]  cnt_q [NumCnt];
  logic [CNT_W-1:0]  cnt_d [NumCnt];
  logic [NumCnt-1:0] cnt_inc;

  // Index 6 counts every accepted push; 0..5 follow the flag bit order.
  assign cnt_inc = {push, {6{push}} & in_flags};

  always_comb begin
    for (int i = 0; i < int'(NumCnt); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sticky_clr) begin
        cnt_d[i] = '0;
      end
      if (cnt_inc[i] && (cnt_d[i] != '1)) begin
        cnt_d[i] = cnt_d[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumCnt); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NumCnt); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    cnt_val = '0;
    for (int i = 0; i < int'(NumCnt); i++) begin
      if (cnt_sel == 3'(i)) begin
        cnt_val = cnt_q[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_result_stage.sv
// Scoreboard bench for fp_result_stage: queue-based reference model plus directed and random traffic.
module tb_fp_result_stage;
  import fp_pkg::*;

  localparam int unsigned P = 16;
  localparam int unsigned D = 4;
`ifdef FP_STAT_CNT_EN
  localparam int unsigned CW = 4;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [P-1:0]     in_sum = '0;
  fp_flags_t        in_flags = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [P-1:0]     out_sum;
  fp_flags_t        out_flags;
  logic [$clog2(D):0] occupancy;
  logic             sticky_clr = 1'b0;
  fp_flags_t        sticky;
  logic             flag_err;
`ifdef FP_STAT_CNT_EN
  logic [2:0]       cnt_sel = 3'd0;
  logic [CW-1:0]    cnt_val;
`endif

  always #5 clk = ~clk;

  fp_result_stage #(
    .PRECISION  (P),
    .FIFO_DEPTH (D)
`ifdef FP_STAT_CNT_EN
    ,
    .CNT_W      (CW)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_flags   (in_flags),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_flags  (out_flags),
    .occupancy  (occupancy),
`ifdef FP_STAT_CNT_EN
    .cnt_sel    (cnt_sel),
    .cnt_val    (cnt_val),
`endif
    .sticky_clr (sticky_clr),
    .sticky     (sticky),
    .flag_err   (flag_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of {sum, flags} and OR-accumulated status.
  logic [P+5:0] exp_q[$];
  fp_flags_t    m_sticky;
  logic         m_err;
  int           m_cnt[7];
  int           m_size;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_sticky = '0;
      m_err    = 1'b0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      m_size = exp_q.size();
      if (sticky_clr) begin
        m_sticky = '0;
        m_err    = 1'b0;
        foreach (m_cnt[i]) m_cnt[i] = 0;
      end
      if (out_ready && m_size > 0) void'(exp_q.pop_front());
      if (in_valid && m_size < int'(D)) begin
        exp_q.push_back({in_sum, in_flags});
        m_sticky = m_sticky | in_flags;
        if ($countones(in_flags) != 1) m_err = 1'b1;
`ifdef FP_STAT_CNT_EN
        for (int i = 0; i < 6; i++) begin
          if (in_flags[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
        end
        if (m_cnt[6] < (1 << CW) - 1) m_cnt[6]++;
`endif
      end
    end
  end

  // Monitor: compares DUT outputs against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    check("in_ready", in_ready, exp_q.size() != int'(D));
    check("out_valid", out_valid, exp_q.size() != 0);
    check("occupancy", occupancy, exp_q.size());
    check("sticky", sticky, m_sticky);
    check("flag_err", flag_err, m_err);
    if (exp_q.size() != 0) check("head_entry", {out_sum, out_flags}, exp_q[0]);
`ifdef FP_STAT_CNT_EN
    check("cnt_val", cnt_val, (cnt_sel == 3'd7) ? 0 : m_cnt[cnt_sel]);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [P-1:0] s, input fp_flags_t f, input bit rdy,
                       input bit clr);
    in_valid   = v;
    in_sum     = s;
    in_flags   = f;
    out_ready  = rdy;
    sticky_clr = clr;
    step();
  endtask

  initial begin
    #12 rst_n = 1'b1;
    step();
    check("empty_sum", out_sum, 0);
    check("empty_flags", out_flags, 0);

    // First result with latency of one cycle.
    drive(1, 16'h3C00, 6'b000001, 1, 0);
    check("first_valid", out_valid, 1);
    check("first_sum", out_sum, 16'h3C00);
    check("first_sticky", sticky, 6'b000001);
    drive(0, 0, 0, 1, 0);

    // Fill to full with the consumer stalled; fifth result is held until a pop frees space.
    for (int i = 0; i < 5; i++) drive(1, 16'h4000 + 16'(i), 6'(1 << (i % 6)), 0, 0);
    check("full_occ", occupancy, 4);
    check("full_ready", in_ready, 0);
    drive(1, 16'h4004, 6'b010000, 1, 0);
    check("ready_after_pop", in_ready, 1);
    drive(1, 16'h4004, 6'b010000, 0, 0);
    repeat (6) drive(0, 0, 0, 1, 0);

    // Steady-state push and pop at occupancy 2.
    drive(1, 16'h5000, 6'b000100, 0, 0);
    drive(1, 16'h5001, 6'b000010, 0, 0);
    for (int i = 0; i < 16; i++) drive(1, 16'($urandom), 6'(1 << $urandom_range(0, 5)), 1, 0);
    check("steady_occ", occupancy, 2);
    repeat (3) drive(0, 0, 0, 1, 0);

    // A clear in the same cycle as an event keeps only that event.
    drive(1, 16'h7E00, 6'b010000, 1, 0);
    drive(1, 16'h7C00, 6'b001000, 1, 1);
    check("clear_with_event", sticky, 6'b001000);
    drive(0, 0, 0, 1, 0);

    // Non-one-hot flags are reported but stored unchanged.
    drive(1, 16'h1234, 6'b000011, 0, 0);
    check("flag_err_set", flag_err, 1);
    check("bad_entry_flags", out_flags, 6'b000011);
    drive(1, 16'h2000, 6'b000001, 0, 0);
    drive(1, 16'h2001, 6'b000001, 0, 0);
    check("pre_reset_occ", occupancy, 3);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_sticky", sticky, 0);
    check("rst_flag_err", flag_err, 0);
    #5 rst_n = 1'b1;
    step();

`ifdef FP_STAT_CNT_EN
    cnt_sel = 3'd2;
    repeat (20) drive(1, 16'h0000, 6'b000100, 1, 0);
    check("cnt_zero_sat", cnt_val, 4'hF);
    cnt_sel = 3'd6;
    drive(0, 0, 0, 1, 0);
    check("cnt_total_sat", cnt_val, 4'hF);
    cnt_sel = 3'd2;
    drive(1, 16'h0000, 6'b000100, 1, 1);
    check("cnt_clear_event", cnt_val, 4'h1);
    drive(0, 0, 0, 1, 0);
`endif

    // Random traffic, mostly legal one-hot flags with occasional malformed ones.
    for (int i = 0; i < 400; i++) begin
`ifdef FP_STAT_CNT_EN
      cnt_sel = 3'($urandom_range(0, 7));
`endif
      drive($urandom_range(0, 3) != 0, 16'($urandom),
            ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'(1 << $urandom_range(0, 5)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end
    repeat (6) drive(0, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
